// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl
//  Brief    : Burst load/store controller over a 256-entry data memory.
//             IDLE accepts a request, BUSY performs len+1 beats at
//             consecutive (wrapping) addresses, and DONE pulses completion.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          wr_en,
    input  logic [7:0]    base_addr,
    input  logic [1:0]    len,
    input  logic [DW-1:0] wdata,
    output logic          wready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [1:0]    cnt_q;
    logic          wr_q;
    logic [7:0]    base_q;
    logic [1:0]    len_q;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    logic [7:0]    beat_addr;
    logic          mem_we;
    logic          mem_re;

    // Contents start at zero; reset deliberately leaves them untouched.
    logic [DW-1:0] mem_q [DEPTH] = '{default: '0};

    // 8-bit sum wraps naturally from 0xFF to 0x00.
    assign beat_addr = base_q + {6'b0, cnt_q};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one beat per BUSY cycle, last beat when count hits len.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == len_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; a store beat is suppressed while reset is asserted.
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        mem_we = (state_q == S_BUSY) && wr_q && !reset;
        mem_re = (state_q == S_BUSY) && !wr_q;
        wready = mem_we;
        rdata  = rdata_q;
        rvalid = rvalid_q;
    end

    // Request capture and beat counting; inputs are only looked at in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= 2'd0;
            wr_q   <= 1'b0;
            base_q <= 8'd0;
            len_q  <= 2'd0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= 2'd0;
            if (req) begin
                wr_q   <= wr_en;
                base_q <= base_addr;
                len_q  <= len;
            end
        end else if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

    // Registered load path: data appears with rvalid one cycle after the beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= mem_re;
            if (mem_re) begin
                rdata_q <= mem_q[beat_addr];
            end
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[beat_addr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_ctrl
//  Brief    : Scoreboard bench for data_mem_ctrl. Loads push expected data
//             from a reference memory; a monitor pops on every rvalid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       wr_en;
    logic [7:0] base_addr;
    logic [1:0] len;
    logic [7:0] wdata;
    logic       wready;
    logic [7:0] rdata;
    logic       rvalid;
    logic       busy;
    logic       done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] last_rd;

    data_mem_ctrl #(.DW(8), .DEPTH(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wr_en     (wr_en),
        .base_addr (base_addr),
        .len       (len),
        .wdata     (wdata),
        .wready    (wready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every rvalid must match the oldest expected load.
    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", {31'd0, rvalid}, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("rdata", {24'd0, rdata}, {24'd0, e});
                last_rd = e;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full burst starting from IDLE; checks per-cycle handshakes.
    task automatic burst(input logic wr, input logic [7:0] base, input logic [1:0] l,
                         input logic [31:0] data);
        req = 1'b1; wr_en = wr; base_addr = base; len = l;
        step();
        req = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            // Garbage on the request inputs must not disturb the burst.
            wr_en = ~wr; base_addr = 8'($urandom); len = 2'($urandom);
            req = 1'($urandom);
            wdata = data[8*i +: 8];
            @(negedge clk);
            check("beat_wready", {31'd0, wready}, {31'd0, wr});
            check("beat_busy",   {31'd0, busy},   32'd1);
            check("beat_done",   {31'd0, done},   32'd0);
            if (wr) ref_mem[8'(base + 8'(i))] = data[8*i +: 8];
            else    exp_q.push_back(ref_mem[8'(base + 8'(i))]);
            step();
        end
        req = 1'b0;
        @(negedge clk);
        check("done_pulse", {31'd0, done},   32'd1);
        check("done_busy",  {31'd0, busy},   32'd1);
        check("done_wrdy",  {31'd0, wready}, 32'd0);
        step();
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("sb_empty",  32'(exp_q.size()), 32'd0);
        step();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
        last_rd = 8'h00;
        reset = 1'b1; req = 1'b0; wr_en = 1'b0; base_addr = 8'h00; len = 2'd0; wdata = 8'h00;
        step();
        step();
        @(negedge clk);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata",  {24'd0, rdata},  32'd0);
        reset = 1'b0;
        step();

        // Single store then load of the same address.
        burst(1'b1, 8'h10, 2'd0, 32'h0000_00A5);
        burst(1'b0, 8'h10, 2'd0, 32'h0);

        // Four-beat burst wrapping past 0xFF.
        burst(1'b1, 8'hFE, 2'd3, 32'h0403_0201);
        burst(1'b0, 8'hFE, 2'd3, 32'h0);
        check("hold_rdata", {24'd0, rdata}, {24'd0, last_rd});
        burst(1'b0, 8'hFF, 2'd1, 32'h0);

        // Request held high: second burst is accepted at cycle 4.
        req = 1'b1; wr_en = 1'b1; base_addr = 8'h50; len = 2'd1;
        for (int c = 0; c <= 8; c++) begin
            logic [7:0] wd;
            wd = 8'(8'h30 + c);
            if (c == 1) base_addr = 8'h60;
            req = (c <= 4);
            wdata = wd;
            @(negedge clk);
            check("hold_done",   {31'd0, done},   {31'd0, (c == 3 || c == 7)});
            check("hold_wready", {31'd0, wready},
                  {31'd0, (c == 1 || c == 2 || c == 5 || c == 6)});
            if (c == 1) ref_mem[8'h50] = wd;
            if (c == 2) ref_mem[8'h51] = wd;
            if (c == 5) ref_mem[8'h60] = wd;
            if (c == 6) ref_mem[8'h61] = wd;
            step();
        end
        req = 1'b0;
        burst(1'b0, 8'h50, 2'd1, 32'h0);
        burst(1'b0, 8'h60, 2'd1, 32'h0);

        // Reset in the third beat of a store aborts the rest.
        req = 1'b1; wr_en = 1'b1; base_addr = 8'h20; len = 2'd3;
        step();
        req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            wdata = 8'(8'hC0 + c);
            if (c == 3) reset = 1'b1;
            else ref_mem[8'(8'h1F + c)] = wdata;
            step();
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd0);
            step();
        end
        burst(1'b0, 8'h20, 2'd3, 32'h0);

        // Reset and request in the same cycle.
        reset = 1'b1; req = 1'b1; wr_en = 1'b1; base_addr = 8'h40; len = 2'd0; wdata = 8'h77;
        step();
        reset = 1'b0; req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rr_busy",   {31'd0, busy},   32'd0);
            check("rr_wready", {31'd0, wready}, 32'd0);
            step();
        end
        burst(1'b0, 8'h40, 2'd0, 32'h0);

        // Idle quiescence with toggling write data.
        for (int c = 0; c < 20; c++) begin
            wdata = 8'($urandom);
            @(negedge clk);
            check("q_outs", {28'd0, wready, rvalid, done, busy}, 32'd0);
            step();
        end
        burst(1'b0, 8'h10, 2'd3, 32'h0);
        burst(1'b0, 8'hFE, 2'd3, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
